sniffer_stream_fifo: RTL and testbench
======================================

// Module: sniffer_stream_fifo
// PURPOSE
//  Parametrised synchronous FIFO with valid/ready on both sides and per-byte keep, first-word-fall-through.
//  Buffers captured sniffer words between capture front-end and downstream packer/DMA.
//  Adds occupancy count, programmable almost-full/almost-empty thresholds and synchronous flush.
//  Single clock domain.
// PARAMETERS
//  DATA_W      64   data width in bits, multiple of 8
//  DEPTH       16   storage words, power of two, >= 4
//  AF_THRESH   12   almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH   2    almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//  clk            in   1                  clock, rising edge
//  s_aresetn      in   1                  asynchronous active-low reset
//  flush          in   1                  synchronous clear of contents, active high
//  s_tdata        in   DATA_W             write data
//  s_tkeep        in   DATA_W/8           byte-valid mask, stored with data
//  s_tvalid       in   1                  write request
//  s_tready       out  1                  space available (= !full)
//  m_tdata        out  DATA_W             head word
//  m_tkeep        out  DATA_W/8           head keep
//  m_tvalid       out  1                  head valid (= !empty)
//  m_tready       in   1                  consumer accepts head
//  count          out  $clog2(DEPTH)+1    words stored, 0..DEPTH
//  full / empty   out  1                  count==DEPTH / count==0
//  almost_full    out  1                  count >= AF_THRESH
//  almost_empty   out  1                  count <= AE_THRESH
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers=0, count=0, s_tready=1, m_tvalid=0, empty=1, full=0,
//    almost_empty=1, almost_full=0; m_tdata/m_tkeep = 0 (storage not cleared).
//  - Push on edge when s_tvalid && s_tready; pop on edge when m_tvalid && m_tready.
//  - Pointers $clog2(DEPTH)+1 bits; MSB is wrap bit; full = addr equal && wrap differ; natural wrap at DEPTH.
//  - FWFT: word pushed into empty FIFO on edge k -> m_tvalid=1, m_tdata valid after edge k (cycle k+1).
//  - m_tdata/m_tkeep = storage[rd_ptr] read combinationally; stable while m_tvalid && !m_tready.
//  - Simultaneous push+pop: allowed when 0<count<DEPTH; count unchanged, both pointers advance.
//  - Full: s_tready=0, push ignored even if pop in same cycle (ready is state-derived, no bypass).
//  - Empty: m_tvalid=0, m_tready ignored, count never underflows.
//  - All flags and count are functions of registered count only; no combinational s_tvalid->s_tready or
//    m_tready->m_tvalid path.
//  - flush=1 on edge: pointers/count -> 0, overrides push and pop that cycle; data in flight discarded.
//  - Reset mid-traffic: contents lost immediately, outputs to reset values asynchronously.
//  - Keep is opaque: stored/returned unchanged, never used to gate data.
// STRUCTURE
//  - Package sniffer_fifo_pkg: default DATA_W/DEPTH constants, function clog2-based ptr width helper,
//    typedef struct packed {logic [DATA_W-1:0] data; logic [DATA_W/8-1:0] keep;} for DATA_W=64 entry.
//  - Sub-module sniffer_fifo_ram: DEPTH x (DATA_W+DATA_W/8) register array, one sync write port,
//    one async read port; top holds pointers, count, flags.
//  - Elaboration asserts: DEPTH power of two, DATA_W%8==0, thresholds in range.
// TESTING (DATA_W=64, DEPTH=16, AF=12, AE=2)
//  1 Reset then push 0xA5A5_0000_0000_0001 keep 0xFF -> next cycle m_tvalid=1, same data/keep, count=1.
//  2 Push 16 words 1..16 with m_tready=0 -> s_tready=0 and full=1 after 16th; almost_full from count=12;
//    17th push held, count stays 16; drain -> 1..16 in order, keep intact, empty=1 at end.
//  3 Fill to 8, then 100 cycles s_tvalid=m_tready=1 -> count stays 8, pointers wrap >=6 times, order kept.
//  4 At count=16 assert push+pop same cycle -> only pop happens, count=15; at count=0 pop -> no change.
//  5 Count=5, flush with push+pop asserted -> count=0, empty=1, next push returns only the new word.
//  6 Random push/pop 10k cycles vs scoreboard model; s_aresetn low mid-burst -> outputs reset within
//    same cycle, post-reset data matches scoreboard restart.

Source files
------------

// File: rtl/sniffer_fifo_pkg.sv
// Shared constants and types for the sniffer stream FIFO.
package sniffer_fifo_pkg;

    localparam int unsigned DefaultDataW = 64;
    localparam int unsigned DefaultDepth = 16;

    typedef struct packed {
        logic [DefaultDataW-1:0]   data;
        logic [DefaultDataW/8-1:0] keep;
    } entry64_t;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sniffer_fifo_ram.sv
// FIFO storage: register array with one synchronous write port and one async read port.
module sniffer_fifo_ram #(
    parameter int unsigned WIDTH = 72,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sniffer_stream_fifo.sv
// First-word-fall-through stream FIFO with keep, occupancy count, threshold flags and flush.
module sniffer_stream_fifo
    import sniffer_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = DefaultDataW,
    parameter int unsigned DEPTH     = DefaultDepth,
    parameter int unsigned AF_THRESH = 12,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                       clk_i,
    input  logic                       s_aresetn_i,
    input  logic                       flush_i,
    input  logic [DATA_W-1:0]          s_tdata_i,
    input  logic [DATA_W/8-1:0]        s_tkeep_i,
    input  logic                       s_tvalid_i,
    output logic                       s_tready_o,
    output logic [DATA_W-1:0]          m_tdata_o,
    output logic [DATA_W/8-1:0]        m_tkeep_o,
    output logic                       m_tvalid_o,
    input  logic                       m_tready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned KW = DATA_W / 8;
    localparam int unsigned EW = DATA_W + KW;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_chk
        $error("DEPTH must be a power of two and at least 4");
    end
    if (DATA_W == 0 || DATA_W % 8 != 0) begin : gen_width_chk
        $error("DATA_W must be a non-zero multiple of 8");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH > DEPTH - 1) begin : gen_thresh_chk
        $error("almost-full/almost-empty thresholds out of range");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          push, pop;
    logic [EW-1:0] rd_entry;

    // Flags depend only on registered state, so there is no ready/valid combinational loop.
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign almost_full_o  = 32'(count_q) >= AF_THRESH;
    assign almost_empty_o = 32'(count_q) <= AE_THRESH;
    assign count_o    = count_q;
    assign s_tready_o = !full_o;
    assign m_tvalid_o = !empty_o;

    assign push = s_tvalid_i && !full_o;
    assign pop  = m_tready_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + PW'(push) - PW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge s_aresetn_i) begin
        if (!s_aresetn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    sniffer_fifo_ram #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (push && !flush_i),
        .waddr_i(wr_ptr_q[AW-1:0]),
        .wdata_i({s_tkeep_i, s_tdata_i}),
        .raddr_i(rd_ptr_q[AW-1:0]),
        .rdata_o(rd_entry)
    );

    // Storage is not reset, so the head is masked to zero while nothing is valid.
    assign m_tdata_o = empty_o ? '0 : rd_entry[DATA_W-1:0];
    assign m_tkeep_o = empty_o ? '0 : rd_entry[EW-1:DATA_W];

endmodule

// File: tb/tb_sniffer_stream_fifo.sv
// Scoreboard bench for sniffer_stream_fifo: directed scenarios plus a long randomized run.
module tb_sniffer_stream_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [4:0]  count;
    logic        full, empty, afull, aempty;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    bit [71:0] exp_q[$];
    int m_sz;

    sniffer_stream_fifo #(
        .DATA_W(64), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk_i(clk_i), .s_aresetn_i(rst_n), .flush_i(flush),
        .s_tdata_i(s_tdata), .s_tkeep_i(s_tkeep), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
        .m_tdata_o(m_tdata), .m_tkeep_o(m_tkeep), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
        .count_o(count), .full_o(full), .empty_o(empty),
        .almost_full_o(afull), .almost_empty_o(aempty)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of accepted words, updated on each accepted handshake.
    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            m_sz = exp_q.size();
            if (m_tready && m_sz > 0) void'(exp_q.pop_front());
            if (s_tvalid && m_sz < DEPTH) exp_q.push_back({s_tkeep, s_tdata});
        end
    end

    // Monitor: compares head word and flags against the model away from the active edge.
    always @(negedge clk_i) begin
        if (mon_en) begin
            int sz;
            sz = exp_q.size();
            chk("count", count, sz);
            chk("m_tvalid", m_tvalid, sz > 0);
            chk("s_tready", s_tready, sz < DEPTH);
            chk("full", full, sz == DEPTH);
            chk("empty", empty, sz == 0);
            chk("almost_full", afull, sz >= AF);
            chk("almost_empty", aempty, sz <= AE);
            if (sz > 0) chk("head", {m_tkeep, m_tdata}, exp_q[0]);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input bit v, input logic [63:0] d, input logic [7:0] k, input bit r,
                         input bit f);
        s_tvalid = v;
        s_tdata  = d;
        s_tkeep  = k;
        m_tready = r;
        flush    = f;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_s_tready"}, s_tready, 1);
        chk({tag, "_m_tvalid"}, m_tvalid, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_aempty"}, aempty, 1);
        chk({tag, "_afull"}, afull, 0);
        chk({tag, "_m_tdata"}, {m_tkeep, m_tdata}, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        step();
        step();
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        step();

        // 1: single word falls through on the following cycle
        drive(1, 64'hA5A5_0000_0000_0001, 8'hFF, 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        chk("t1_m_tvalid", m_tvalid, 1);
        chk("t1_head", {m_tkeep, m_tdata}, {8'hFF, 64'hA5A5_0000_0000_0001});
        chk("t1_count", count, 1);
        drive(0, '0, '0, 1, 0);
        step();
        drive(0, '0, '0, 0, 0);

        // 2: fill to full, overflow push held, then drain in order
        for (int i = 1; i <= 16; i++) begin
            drive(1, 64'(i), 8'(i) ^ 8'h3C, 0, 0);
            step();
            chk("t2_afull", afull, i >= AF);
        end
        chk("t2_full", full, 1);
        chk("t2_s_tready", s_tready, 0);
        drive(1, 64'hDEAD, 8'h01, 0, 0);
        step();
        chk("t2_hold_count", count, 16);
        drive(0, '0, '0, 1, 0);
        for (int i = 1; i <= 16; i++) begin
            chk("t2_drain", {m_tkeep, m_tdata}, {8'(i) ^ 8'h3C, 64'(i)});
            step();
        end
        chk("t2_empty", empty, 1);

        // 3: steady push+pop at half occupancy, pointers wrap many times
        for (int i = 0; i < 8; i++) begin
            drive(1, 64'(100 + i), 8'hF0, 0, 0);
            step();
        end
        for (int i = 0; i < 100; i++) begin
            drive(1, 64'(200 + i), 8'(i), 1, 0);
            step();
        end
        chk("t3_count", count, 8);
        drive(0, '0, '0, 1, 0);
        for (int i = 0; i < 8; i++) step();

        // 4: push+pop at full only pops; pop at empty does nothing
        for (int i = 0; i < 16; i++) begin
            drive(1, {32'hCAFE, 32'(i)}, 8'h55, 0, 0);
            step();
        end
        drive(1, 64'hBAD, 8'hAA, 1, 0);
        step();
        chk("t4_full_pushpop", count, 15);
        drive(0, '0, '0, 1, 0);
        for (int i = 0; i < 15; i++) step();
        step();
        chk("t4_empty_pop", count, 0);

        // 5: flush overrides push and pop, then only new data returns
        for (int i = 0; i < 5; i++) begin
            drive(1, 64'(300 + i), 8'h0F, 0, 0);
            step();
        end
        drive(1, 64'h999, 8'h99, 1, 1);
        step();
        chk("t5_flush_count", count, 0);
        chk("t5_flush_empty", empty, 1);
        drive(1, 64'h1234_5678_9ABC_DEF0, 8'h3C, 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        chk("t5_new_head", {m_tkeep, m_tdata}, {8'h3C, 64'h1234_5678_9ABC_DEF0});
        chk("t5_new_count", count, 1);

        // 6: randomized traffic with varying bias, occasional flush, reset mid-burst
        for (int i = 0; i < 10000; i++) begin
            int pv, pr;
            pv = ((i / 500) % 3 == 0) ? 80 : (((i / 500) % 3 == 1) ? 30 : 55);
            pr = ((i / 500) % 3 == 0) ? 30 : (((i / 500) % 3 == 1) ? 80 : 55);
            drive($urandom_range(0, 99) < pv, {$urandom, $urandom}, 8'($urandom),
                  $urandom_range(0, 99) < pr, $urandom_range(0, 299) == 0);
            if (i == 5000) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("midreset");
                step();
                step();
                #2 rst_n = 1'b1;
            end
            step();
        end
        drive(0, '0, '0, 1, 0);
        for (int i = 0; i < 20; i++) step();
        chk("final_empty", empty, 1);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
